// File: rtl/player_laser_pkg.sv
// player_laser_pkg: shared screen, sprite and laser constants plus the laser FSM state encoding.
package player_laser_pkg;
  localparam int RES_H = 640;
  localparam int RES_V = 480;
  localparam int PLAYER_WIDTH_SCALED = 32;
  localparam int PROJ_WIDTH_SCALED = 4;
  localparam int PROJ_HEIGHT_SCALED = 16;
  localparam int PLAYER_Y = 440;
  localparam int LASER_STEP = 8;
  localparam int LASER_TOP_LIMIT = 32;
  localparam int LASER_EXPLODE_FRAMES = 8;
  localparam int LASER_COOLDOWN_FRAMES = 4;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    EXPLODE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;
endpackage

// File: rtl/fire_edge_latch.sv
// fire_edge_latch: registered rising-edge detect on d with a pending flag (set-enable, clear wins).
module fire_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic set_en,
  input  logic clr,
  output logic pending
);
  logic d_q;
  logic rise;
  assign rise = d & ~d_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      pending <= 1'b0;
    end else begin
      d_q     <= d;
      pending <= clr ? 1'b0 : (rise & set_en) ? 1'b1 : pending;
    end
  end
endmodule

// File: rtl/player_laser.sv
// player_laser: single upward player laser - launch, flight, explosion and cooldown.
module player_laser
  import player_laser_pkg::*;
#(
  parameter int LASER_STEP_P    = LASER_STEP,
  parameter int PLAYER_Y_P      = PLAYER_Y,
  parameter int PLAYER_W        = PLAYER_WIDTH_SCALED,
  parameter int PROJ_W          = PROJ_WIDTH_SCALED,
  parameter int PROJ_H          = PROJ_HEIGHT_SCALED,
  parameter int TOP_LIMIT       = LASER_TOP_LIMIT,
  parameter int EXPLODE_FRAMES  = LASER_EXPLODE_FRAMES,
  parameter int COOLDOWN_FRAMES = LASER_COOLDOWN_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic       hit,
  output logic [9:0] laser_x,
  output logic [9:0] laser_y,
  output logic       laser_active,
  output logic       laser_exploding,
  output logic       shot_fired
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [9:0] x_n, y_n;
  logic act_n, exp_n, sf_n, pending, launch;
  logic [10:0] x_sum;
  assign x_sum = {1'b0, player_x} + 11'(PLAYER_W / 2 - PROJ_W / 2);
  assign launch = (state == IDLE) && frame && pending;
  fire_edge_latch u_fire (
    .clk     (clk),
    .rst     (rst),
    .d       (fire),
    .set_en  (state == IDLE),
    .clr     (launch),
    .pending (pending)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = laser_x;
    y_n     = laser_y;
    act_n   = laser_active;
    exp_n   = laser_exploding;
    sf_n    = 1'b0;
    case (state)
      IDLE: if (launch) begin
        state_n = FLYING;
        x_n     = (x_sum > 11'(RES_H - PROJ_W)) ? 10'(RES_H - PROJ_W) : x_sum[9:0];
        y_n     = 10'(PLAYER_Y_P - PROJ_H);
        act_n   = 1'b1;
        sf_n    = 1'b1;
      end
      // Compare before subtracting so laser_y never wraps past the top.
      FLYING: if (hit || (frame && laser_y < 10'(TOP_LIMIT + LASER_STEP_P))) begin
        state_n = EXPLODE;
        act_n   = 1'b0;
        exp_n   = 1'b1;
        cnt_n   = 4'd0;
      end else if (frame) begin
        y_n = laser_y - 10'(LASER_STEP_P);
      end
      EXPLODE: if (frame) begin
        if (cnt == 4'(EXPLODE_FRAMES - 1)) begin
          state_n = COOLDOWN;
          cnt_n   = 4'd0;
          exp_n   = 1'b0;
          y_n     = 10'(RES_V);
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      COOLDOWN: if (frame) begin
        state_n = (cnt == 4'(COOLDOWN_FRAMES - 1)) ? IDLE : COOLDOWN;
        cnt_n   = (cnt == 4'(COOLDOWN_FRAMES - 1)) ? 4'd0 : cnt + 4'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      laser_x         <= 10'd0;
      laser_y         <= 10'(RES_V);
      laser_active    <= 1'b0;
      laser_exploding <= 1'b0;
      shot_fired      <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      laser_x         <= x_n;
      laser_y         <= y_n;
      laser_active    <= act_n;
      laser_exploding <= exp_n;
      shot_fired      <= sf_n;
    end
  end
endmodule

// File: tb/tb_player_laser.sv
// tb_player_laser: directed self-checking bench for player_laser.
module tb_player_laser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame = 1'b0;
  logic fire = 1'b0;
  logic hit = 1'b0;
  logic [9:0] player_x = 10'd0;
  logic [9:0] laser_x, laser_y;
  logic laser_active, laser_exploding, shot_fired;
  int n_asserts = 0;
  int n_fails = 0;
  always #5 clk = ~clk;
  player_laser dut (
    .clk             (clk),
    .rst             (rst),
    .frame           (frame),
    .fire            (fire),
    .player_x        (player_x),
    .hit             (hit),
    .laser_x         (laser_x),
    .laser_y         (laser_y),
    .laser_active    (laser_active),
    .laser_exploding (laser_exploding),
    .shot_fired      (shot_fired)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_frame(input int n);
    repeat (n) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
    end
  endtask
  task automatic press();
    fire = 1'b1;
    tick(1);
    fire = 1'b0;
    tick(1);
  endtask
  task automatic hit_pulse();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("reset_x", laser_x, 0);
    chk("reset_y", laser_y, 480);
    chk("reset_active", laser_active, 0);
    chk("reset_expl", laser_exploding, 0);
    chk("reset_sf", shot_fired, 0);
    rst = 1'b0;
    tick(1);
    // launch position and first move
    player_x = 10'd100;
    press();
    do_frame(1);
    chk("launch_sf", shot_fired, 1);
    chk("launch_x", laser_x, 114);
    chk("launch_y", laser_y, 424);
    chk("launch_active", laser_active, 1);
    tick(1);
    chk("sf_one_cycle", shot_fired, 0);
    do_frame(1);
    chk("move_y", laser_y, 416);
    // top-of-screen miss
    do_frame(48);
    chk("top_y", laser_y, 32);
    chk("top_active", laser_active, 1);
    do_frame(1);
    chk("miss_expl", laser_exploding, 1);
    chk("miss_y", laser_y, 32);
    chk("miss_active", laser_active, 0);
    do_frame(7);
    chk("expl_held", laser_exploding, 1);
    do_frame(1);
    chk("expl_done", laser_exploding, 0);
    chk("expl_done_y", laser_y, 480);
    // press during cooldown is discarded
    do_frame(3);
    press();
    do_frame(1);
    do_frame(2);
    chk("cooldown_press_ignored", laser_active, 0);
    press();
    do_frame(1);
    chk("relaunch_sf", shot_fired, 1);
    chk("relaunch_active", laser_active, 1);
    // hit coincident with frame at y=200
    do_frame(28);
    chk("pre_hit_y", laser_y, 200);
    hit = 1'b1;
    frame = 1'b1;
    tick(1);
    hit = 1'b0;
    frame = 1'b0;
    chk("hit_expl", laser_exploding, 1);
    chk("hit_y", laser_y, 200);
    chk("hit_active", laser_active, 0);
    hit = 1'b1;
    tick(3);
    hit = 1'b0;
    chk("hit_in_expl_expl", laser_exploding, 1);
    chk("hit_in_expl_y", laser_y, 200);
    do_frame(7);
    chk("hit_expl_held", laser_exploding, 1);
    do_frame(1);
    chk("hit_expl_done", laser_exploding, 0);
    do_frame(4);
    // fire held through a whole shot: no auto-repeat
    fire = 1'b1;
    tick(1);
    do_frame(1);
    chk("held_launch", shot_fired, 1);
    hit_pulse();
    do_frame(14);
    chk("held_no_repeat", laser_active, 0);
    fire = 1'b0;
    tick(1);
    press();
    do_frame(1);
    chk("release_press_sf", shot_fired, 1);
    chk("release_press_active", laser_active, 1);
    // press coincident with frame launches on the following frame
    hit_pulse();
    do_frame(12);
    fire = 1'b1;
    frame = 1'b1;
    tick(1);
    fire = 1'b0;
    frame = 1'b0;
    chk("coincident_no_launch", laser_active, 0);
    do_frame(1);
    chk("coincident_next_launch", laser_active, 1);
    // saturation
    hit_pulse();
    do_frame(12);
    player_x = 10'd630;
    press();
    do_frame(1);
    chk("sat_x", laser_x, 636);
    chk("sat_y", laser_y, 424);
    // asynchronous reset mid-flight
    do_frame(3);
    chk("pre_rst_active", laser_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_active", laser_active, 0);
    chk("async_rst_y", laser_y, 480);
    tick(1);
    rst = 1'b0;
    tick(1);
    do_frame(2);
    chk("post_rst_no_shot", laser_active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/player_laser.md
Name: player_laser

Overview:
- Controls the player's single upward-travelling laser. It is the opposite-direction counterpart to the invaders' downward missile logic.
- Takes the fire button, player position, per-frame tick and a hit pulse from the collision detector.
- Produces the laser position and status for the renderer and collision logic.
- Only one player laser exists on screen at a time. A new shot is allowed only after the previous shot's explosion and cooldown have finished.

Parameters:
- LASER_STEP, 8: pixels moved up per frame.
- PLAYER_Y, 440: top row of the player sprite.
- PLAYER_W, 32: scaled player sprite width.
- PROJ_W, 4: scaled projectile width.
- PROJ_H, 16: scaled projectile height.
- TOP_LIMIT, 32: topmost row the laser may occupy before it explodes.
- EXPLODE_FRAMES, 8: number of frames in the explosion.
- COOLDOWN_FRAMES, 4: number of frames after the explosion before the next shot is accepted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- frame, input, 1: one-clk pulse per video frame.
- fire, input, 1: fire button level, already synchronised to clk.
- player_x, input, 10: player sprite left x.
- hit, input, 1: collision pulse; the laser overlapped an invader or shield.
- laser_x, output, 10: laser left x.
- laser_y, output, 10: laser top y.
- laser_active, output, 1: laser is in flight and should be drawn.
- laser_exploding, output, 1: draw the explosion sprite at laser_x/laser_y.
- shot_fired, output, 1: one-clk pulse issued on launch.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE.
  - laser_x 0, laser_y 480 (off-screen).
  - laser_active 0, laser_exploding 0, shot_fired 0.
  - Frame counter 0; pending 0.
- Fire capture:
  - Rising-edge detect on fire; the previous fire level is registered.
  - A rise while in IDLE sets pending.
  - Rises in any other state are discarded, so holding fire never auto-repeats.
- IDLE:
  - When frame=1 and pending=1, launch:
    - laser_x = player_x + PLAYER_W/2 - PROJ_W/2, computed in 11 bits and saturated to 640-PROJ_W.
    - laser_y = PLAYER_Y - PROJ_H.
    - laser_active <= 1; shot_fired = 1 for that cycle; pending cleared; go to FLYING.
  - hit is ignored in IDLE.
- FLYING:
  - hit=1 (any cycle): go to EXPLODE; position frozen; laser_active <= 0; laser_exploding <= 1; counter <= 0.
  - hit and frame in the same cycle: hit wins and there is no move.
  - frame=1, no hit, and laser_y < TOP_LIMIT+LASER_STEP: go to EXPLODE at the current y; this is a top-of-screen miss.
  - frame=1, no hit, otherwise: laser_y <= laser_y - LASER_STEP. The compare happens first, so the subtraction never underflows.
- EXPLODE:
  - Each frame increments the counter.
  - On a frame with counter==EXPLODE_FRAMES-1: go to COOLDOWN, counter <= 0, laser_exploding <= 0, laser_y <= 480.
  - Exactly EXPLODE_FRAMES frame pulses are spent in EXPLODE.
- COOLDOWN:
  - Same counting with COOLDOWN_FRAMES, then go to IDLE.
  - hit is ignored in EXPLODE and COOLDOWN.
- Reset mid-flight or mid-explosion returns immediately to the reset values; a pending shot is lost.
- The counter is 4 bits, so EXPLODE_FRAMES and COOLDOWN_FRAMES must each be ≤ 16.
- Launch latency: the shot is visible from the frame pulse that launches it. A press in IDLE launches on the next frame pulse; a press coincident with a frame pulse launches on the following frame.

Decomposition:
- Shared constants include: add RES_V, RES_H, PROJ_WIDTH_SCALED, PROJ_HEIGHT_SCALED, PLAYER_Y, LASER_STEP and the 2-bit state encodings (IDLE=0, FLYING=1, EXPLODE=2, COOLDOWN=3) alongside the existing sprite constants.
- One natural sub-module, fire_edge_latch: registered rising-edge detect plus a pending flag with set-enable and clear.
- The FSM and the frame counter stay in player_laser.

Test Plan:
- Launch position: player_x=100, pulse fire, then one frame -> shot_fired pulse, laser_x=114, laser_y=424, laser_active=1. After one more frame, laser_y=416.
- Top-of-screen miss, same launch, no hit:
  - After 49 further frames, laser_y=32.
  - The 50th frame gives laser_exploding=1 at y=32.
  - 8 frames later laser_exploding=0.
  - 4 frames after that, a new fire press is accepted.
- Hit during flight:
  - hit at laser_y=200 coincident with a frame -> EXPLODE with laser_y still 200, laser_active=0.
  - Further hits during EXPLODE do not change state.
- Fire held continuously through one entire shot cycle -> no second shot. Release then press -> launch on the next frame.
- Press during COOLDOWN -> ignored; IDLE reached with pending=0, and no shot without a new press.
- Saturation and reset:
  - player_x=630 -> laser_x clamped to 636.
  - rst asserted mid-flight -> laser_active=0 and laser_y=480 immediately, without waiting for clk.
